// File: rtl/rng_challenge_sampler_pkg.sv
// rng_challenge_sampler_pkg: state encoding and RCT run-counter width shared by the sampler and its health monitor.
// No ports; provides rng_state_t and RCT_CNT_W.
package cmac_rng_pkg;
    typedef enum logic [2:0] {IDLE, WARMUP, SAMPLE, HOLD, FAIL} rng_state_t;
    localparam int RCT_CNT_W = 8;
endpackage

// File: rtl/rng_challenge_sampler_if.sv
// rng_challenge_sampler_if: control, entropy and challenge handshake bundle between a requester and the sampler.
// Ports (sampler view): start_i, abort_i, bit_in_i, bit_valid_i, out_ready_i in; challenge_o, out_valid_o, busy_o, health_fail_o out.
interface rng_challenge_sampler_if #(
    parameter int WIDTH = 64
);
    logic             start_i;
    logic             abort_i;
    logic             bit_in_i;
    logic             bit_valid_i;
    logic             out_ready_i;
    logic [WIDTH-1:0] challenge_o;
    logic             out_valid_o;
    logic             busy_o;
    logic             health_fail_o;
    modport master (
        output start_i, abort_i, bit_in_i, bit_valid_i, out_ready_i,
        input  challenge_o, out_valid_o, busy_o, health_fail_o
    );
    modport slave (
        input  start_i, abort_i, bit_in_i, bit_valid_i, out_ready_i,
        output challenge_o, out_valid_o, busy_o, health_fail_o
    );
endinterface

// File: rtl/rng_challenge_sampler_rct.sv
// rng_rct_monitor: repetition-count health test over accepted entropy bits.
// Ports: clk_i, reset_ni (async, active-low), clear_i (restart history), bit_in_i, bit_accept_i in; trip_o out.
module rng_rct_monitor
    import cmac_rng_pkg::*;
#(
    parameter int RCT_LIMIT = 24
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic clear_i,
    input  logic bit_in_i,
    input  logic bit_accept_i,
    output logic trip_o
);
    logic [RCT_CNT_W-1:0] run_q, run_d;
    logic                 last_q, last_d;
    // A zero run marks empty history, so the first bit after clear always starts a run of one.
    always_comb begin
        run_d  = run_q;
        last_d = last_q;
        if (clear_i) begin
            run_d  = '0;
            last_d = 1'b0;
        end else if (bit_accept_i) begin
            last_d = bit_in_i;
            run_d  = (run_q == '0 || bit_in_i != last_q) ? RCT_CNT_W'(1) : (&run_q ? run_q : run_q + 1'b1);
        end
    end
    // Trip is combinational on the accepting cycle so the FSM leaves for FAIL on the very next edge.
    assign trip_o = bit_accept_i && run_d >= RCT_CNT_W'(RCT_LIMIT);
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            run_q  <= '0;
            last_q <= 1'b0;
        end else begin
            run_q  <= run_d;
            last_q <= last_d;
        end
    end
endmodule

// File: rtl/rng_challenge_sampler.sv
// rng_challenge_sampler: collects a WIDTH-bit challenge from a bit-serial entropy source after a warm-up discard, with RCT health checking.
// Ports: clk_i, reset_ni (async, active-low); bus (slave modport of rng_challenge_sampler_if).
module rng_challenge_sampler
    import cmac_rng_pkg::rng_state_t;
#(
    parameter int WIDTH     = 64,
    parameter int WARMUP    = 16,
    parameter bit MSB_FIRST = 1'b0,
    parameter int RCT_LIMIT = 24
) (
    input logic                    clk_i,
    input logic                    reset_ni,
    rng_challenge_sampler_if.slave bus
);
    // Enum constants are package-qualified because the WARMUP state shares its name with the parameter.
    localparam int WCW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam int SCW = $clog2(WIDTH + 1);
    rng_state_t       state_q, state_d;
    logic [WCW-1:0]   wcnt_q, wcnt_d;
    logic [SCW-1:0]   scnt_q, scnt_d;
    logic [WIDTH-1:0] chal_q, chal_d;
    logic             hf_q, hf_d;
    logic             busy, accept, trip, rct_clear;
    assign busy   = state_q == cmac_rng_pkg::WARMUP || state_q == cmac_rng_pkg::SAMPLE;
    assign accept = busy && bus.bit_valid_i && !bus.abort_i;
    rng_rct_monitor #(.RCT_LIMIT(RCT_LIMIT)) u_rct (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .clear_i      (rct_clear),
        .bit_in_i     (bus.bit_in_i),
        .bit_accept_i (accept),
        .trip_o       (trip)
    );
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        scnt_d    = scnt_q;
        chal_d    = chal_q;
        hf_d      = hf_q;
        rct_clear = 1'b0;
        if (bus.abort_i) begin
            state_d = cmac_rng_pkg::IDLE;
            wcnt_d  = '0;
            scnt_d  = '0;
            chal_d  = busy ? '0 : chal_q;
        end else begin
            case (state_q)
                cmac_rng_pkg::IDLE, cmac_rng_pkg::FAIL: if (bus.start_i) begin
                    if (WARMUP > 0) state_d = cmac_rng_pkg::WARMUP;
                    else            state_d = cmac_rng_pkg::SAMPLE;
                    wcnt_d    = '0;
                    scnt_d    = '0;
                    chal_d    = '0;
                    hf_d      = (state_q == cmac_rng_pkg::FAIL) ? 1'b0 : hf_q;
                    rct_clear = 1'b1;
                end
                cmac_rng_pkg::WARMUP: if (trip) begin
                    state_d = cmac_rng_pkg::FAIL;
                    hf_d    = 1'b1;
                end else if (accept) begin
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_d == WCW'(WARMUP)) state_d = cmac_rng_pkg::SAMPLE;
                end
                // A trip on the final bit still wins, so a partial or unhealthy word is never presented.
                cmac_rng_pkg::SAMPLE: if (trip) begin
                    state_d = cmac_rng_pkg::FAIL;
                    hf_d    = 1'b1;
                end else if (accept) begin
                    chal_d = MSB_FIRST ? {bus.bit_in_i, chal_q[WIDTH-1:1]} : {chal_q[WIDTH-2:0], bus.bit_in_i};
                    scnt_d = scnt_q + 1'b1;
                    if (scnt_d == SCW'(WIDTH)) state_d = cmac_rng_pkg::HOLD;
                end
                cmac_rng_pkg::HOLD: if (bus.out_ready_i) state_d = cmac_rng_pkg::IDLE;
                default: state_d = cmac_rng_pkg::IDLE;
            endcase
        end
    end
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= cmac_rng_pkg::IDLE;
            wcnt_q  <= '0;
            scnt_q  <= '0;
            chal_q  <= '0;
            hf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            scnt_q  <= scnt_d;
            chal_q  <= chal_d;
            hf_q    <= hf_d;
        end
    end
    assign bus.challenge_o   = chal_q;
    assign bus.out_valid_o   = state_q == cmac_rng_pkg::HOLD;
    assign bus.busy_o        = busy;
    assign bus.health_fail_o = hf_q;
endmodule

// File: tb/tb_rng_challenge_sampler.sv
// tb_rng_challenge_sampler: drives a default sampler and a small MSB-first sampler with shared stimulus against a transaction-level model.
module tb_rng_challenge_sampler;
    localparam int AW = 64, AWU = 16, ALIM = 24;
    localparam int BW = 8,  BWU = 0,  BLIM = 4;
    localparam bit AMF = 1'b0, BMF = 1'b1;
    typedef enum {M_IDLE, M_RUN, M_HOLD, M_FAIL} mode_t;
    logic clk = 1'b0, rst_n = 1'b0;
    logic start = 1'b0, abort = 1'b0, bit_in = 1'b0, bit_valid = 1'b0, out_ready = 1'b0;
    int checks = 0, failures = 0;
    int lat, latb, acc;
    logic [7:0] pat;
    mode_t mode [2];
    bit hf [2];
    int n [2];
    bit hist [2][512];
    logic [255:0] word [2];
    rng_challenge_sampler_if #(.WIDTH(AW)) ifa ();
    rng_challenge_sampler_if #(.WIDTH(BW)) ifb ();
    assign ifa.start_i = start;      assign ifb.start_i = start;
    assign ifa.abort_i = abort;      assign ifb.abort_i = abort;
    assign ifa.bit_in_i = bit_in;    assign ifb.bit_in_i = bit_in;
    assign ifa.bit_valid_i = bit_valid; assign ifb.bit_valid_i = bit_valid;
    assign ifa.out_ready_i = out_ready; assign ifb.out_ready_i = out_ready;
    rng_challenge_sampler #(.WIDTH(AW), .WARMUP(AWU), .MSB_FIRST(AMF), .RCT_LIMIT(ALIM)) dut_a (
        .clk_i(clk), .reset_ni(rst_n), .bus(ifa));
    rng_challenge_sampler #(.WIDTH(BW), .WARMUP(BWU), .MSB_FIRST(BMF), .RCT_LIMIT(BLIM)) dut_b (
        .clk_i(clk), .reset_ni(rst_n), .bus(ifb));
    always #5 clk = ~clk;
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
    function automatic int width(int k); return k == 0 ? AW : BW; endfunction
    function automatic int warm(int k);  return k == 0 ? AWU : BWU; endfunction
    function automatic int lim(int k);   return k == 0 ? ALIM : BLIM; endfunction
    function automatic bit msb(int k);   return k == 0 ? AMF : BMF; endfunction
    function automatic int tail_run(int k);
        int r = 1;
        for (int i = n[k] - 1; i > 0 && hist[k][i-1] == hist[k][n[k]-1]; i--) r++;
        return r;
    endfunction
    // Kept bits are those after warm-up; the first kept bit ends at the far end of the word.
    function automatic logic [255:0] build(int k);
        logic [255:0] w = '0;
        for (int i = 0; i < width(k); i++)
            if (msb(k)) w[i] = hist[k][warm(k) + i];
            else        w[width(k) - 1 - i] = hist[k][warm(k) + i];
        return w;
    endfunction
    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            mode[k] = M_IDLE;
            hf[k]   = 1'b0;
            n[k]    = 0;
            word[k] = '0;
        end
    endfunction
    function automatic void model_step(int k);
        if (abort) mode[k] = M_IDLE;
        else case (mode[k])
            M_IDLE, M_FAIL: if (start) begin
                if (mode[k] == M_FAIL) hf[k] = 1'b0;
                n[k]    = 0;
                mode[k] = M_RUN;
            end
            M_RUN: if (bit_valid) begin
                hist[k][n[k]] = bit_in;
                n[k]++;
                if (tail_run(k) >= lim(k)) begin
                    mode[k] = M_FAIL;
                    hf[k]   = 1'b1;
                end else if (n[k] == warm(k) + width(k)) begin
                    word[k] = build(k);
                    mode[k] = M_HOLD;
                end
            end
            M_HOLD: if (out_ready) mode[k] = M_IDLE;
            default: mode[k] = M_IDLE;
        endcase
    endfunction
    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic compare_all();
        check("a_busy",  256'(ifa.busy_o),        256'(mode[0] == M_RUN));
        check("a_valid", 256'(ifa.out_valid_o),   256'(mode[0] == M_HOLD));
        check("a_hf",    256'(ifa.health_fail_o), 256'(hf[0]));
        check("b_busy",  256'(ifb.busy_o),        256'(mode[1] == M_RUN));
        check("b_valid", 256'(ifb.out_valid_o),   256'(mode[1] == M_HOLD));
        check("b_hf",    256'(ifb.health_fail_o), 256'(hf[1]));
        if (mode[0] == M_HOLD) check("a_word", 256'(ifa.challenge_o), word[0]);
        if (mode[1] == M_HOLD) check("b_word", 256'(ifb.challenge_o), word[1]);
    endtask
    task automatic step();
        @(posedge clk);
        if (rst_n) for (int k = 0; k < 2; k++) model_step(k);
        #1 compare_all();
    endtask
    task automatic do_abort();
        start = 1'b0; bit_valid = 1'b0; out_ready = 1'b0; abort = 1'b1;
        step();
        abort = 1'b0;
    endtask
    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_busy",  256'(ifa.busy_o),        256'(0));
        check("rst_a_valid", 256'(ifa.out_valid_o),   256'(0));
        check("rst_a_hf",    256'(ifa.health_fail_o), 256'(0));
        check("rst_a_word",  256'(ifa.challenge_o),   256'(0));
        @(negedge clk) rst_n = 1'b1;
        step();
        // Alternating stream, continuous valid: A latency 81, B latency 9.
        start = 1'b1; step(); start = 1'b0;
        lat = 1; latb = 0; bit_valid = 1'b1; bit_in = 1'b1;
        while (!ifa.out_valid_o && lat < 200) begin
            step(); lat++;
            if (ifb.out_valid_o && latb == 0) latb = lat;
            bit_in = ~bit_in;
        end
        check("lat_a_alt", 256'(lat), 256'(81));
        check("lat_b_alt", 256'(latb), 256'(9));
        check("word_a_alt", 256'(ifa.challenge_o), 256'(64'hAAAA_AAAA_AAAA_AAAA));
        check("word_b_alt", 256'(ifb.challenge_o), 256'(8'h55));
        bit_valid = 1'b0;
        repeat (3) step();
        check("hold_a_valid", 256'(ifa.out_valid_o), 256'(1));
        out_ready = 1'b1; step(); out_ready = 1'b0;
        check("idle_a_valid", 256'(ifa.out_valid_o), 256'(0));
        check("idle_a_busy",  256'(ifa.busy_o), 256'(0));
        check("idle_a_keep",  256'(ifa.challenge_o), 256'(64'hAAAA_AAAA_AAAA_AAAA));
        // MSB-first pattern on B.
        start = 1'b1; step(); start = 1'b0;
        pat = 8'b1101_0010; bit_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("b_pat_early", 256'(ifb.out_valid_o), 256'(0));
            bit_in = pat[7 - i];
            step();
        end
        check("b_pat_valid", 256'(ifb.out_valid_o), 256'(1));
        check("b_pat_word",  256'(ifb.challenge_o), 256'(8'h4B));
        do_abort();
        // Constant zero stream trips the RCT.
        start = 1'b1; step(); start = 1'b0;
        lat = 1; latb = 0; bit_valid = 1'b1; bit_in = 1'b0;
        while (!ifa.health_fail_o && lat < 200) begin
            step(); lat++;
            if (ifb.health_fail_o && latb == 0) latb = lat;
        end
        check("rct_a_lat", 256'(lat), 256'(25));
        check("rct_b_lat", 256'(latb), 256'(5));
        check("rct_a_valid", 256'(ifa.out_valid_o), 256'(0));
        bit_valid = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        check("rct_a_clear", 256'(ifa.health_fail_o), 256'(0));
        check("rct_b_clear", 256'(ifb.health_fail_o), 256'(0));
        check("rct_a_busy",  256'(ifa.busy_o), 256'(1));
        do_abort();
        // Gapped valid on B: same word, latency doubled.
        start = 1'b1; step(); start = 1'b0;
        lat = 1; acc = 0;
        while (!ifb.out_valid_o && lat < 200) begin
            bit_valid = (lat % 2 == 1);
            bit_in = (acc % 2 == 0);
            step();
            if (bit_valid) acc++;
            lat++;
        end
        check("gap_b_lat",  256'(lat), 256'(16));
        check("gap_b_word", 256'(ifb.challenge_o), 256'(8'h55));
        do_abort();
        // Abort on the 30th sample bit, then a fresh full run.
        start = 1'b1; step(); start = 1'b0;
        bit_valid = 1'b1; bit_in = 1'b1;
        for (int i = 0; i < 45; i++) begin step(); bit_in = ~bit_in; end
        abort = 1'b1; step(); abort = 1'b0;
        check("abort_a_busy",  256'(ifa.busy_o), 256'(0));
        check("abort_a_valid", 256'(ifa.out_valid_o), 256'(0));
        start = 1'b1; step(); start = 1'b0;
        lat = 1;
        while (!ifa.out_valid_o && lat < 200) begin
            bit_in = 1'($urandom_range(0, 1));
            step(); lat++;
        end
        check("fresh_a_lat", 256'(lat), 256'(81));
        out_ready = 1'b1; step(); out_ready = 1'b0;
        // Asynchronous reset between edges mid-SAMPLE.
        start = 1'b1; step(); start = 1'b0;
        bit_valid = 1'b1;
        repeat (30) begin bit_in = 1'($urandom_range(0, 1)); step(); end
        #3 rst_n = 1'b0;
        #1;
        check("arst_a_busy",  256'(ifa.busy_o),        256'(0));
        check("arst_a_valid", 256'(ifa.out_valid_o),   256'(0));
        check("arst_a_word",  256'(ifa.challenge_o),   256'(0));
        check("arst_a_hf",    256'(ifa.health_fail_o), 256'(0));
        check("arst_b_hf",    256'(ifb.health_fail_o), 256'(0));
        model_reset();
        start = 1'b1;
        repeat (2) step();
        @(negedge clk) begin rst_n = 1'b1; start = 1'b0; bit_valid = 1'b0; end
        step();
        // Randomized traffic, alternating fair and sticky bit segments.
        for (int i = 0; i < 4000; i++) begin
            start     = ($urandom_range(0, 9) == 0);
            abort     = ($urandom_range(0, 149) == 0);
            out_ready = ($urandom_range(0, 3) == 0);
            bit_valid = ($urandom_range(0, 3) != 0);
            if (i % 800 < 400) bit_in = 1'($urandom_range(0, 1));
            else if ($urandom_range(0, 11) == 0) bit_in = ~bit_in;
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rng_challenge_sampler.md
Name: rng_challenge_sampler

Overview:
- Parametrised successor of the fixed 64-bit ASG challenge sampler in the SPI/CMAC path.
- Collects WIDTH bits from a bit-serial entropy source (ASG) into a challenge word, after an optional warm-up discard.
- Runs a repetition-count health test on every accepted bit.
- Presents the result on a valid/ready handshake to the CMAC challenge logic.

Parameters:
- WIDTH, 64, challenge length in bits (8..256).
- WARMUP, 16, source bits discarded after each start before collection (0 = none).
- MSB_FIRST, 0: 0 = shift left, new bit enters bit 0; 1 = shift right, new bit enters bit WIDTH-1.
- RCT_LIMIT, 24, identical consecutive accepted bits (warm-up included) that trip the health failure (2..255).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request for a new challenge; honoured only in IDLE.
- abort  in  1  synchronous cancel; returns to IDLE from any state.
- bit_in  in  1  entropy bit from ASG.
- bit_valid  in  1  bit_in qualifier; a bit is accepted on a cycle with bit_valid=1 in WARMUP or SAMPLE.
- challenge  out  WIDTH  collected word; stable while out_valid=1.
- out_valid  out  1  challenge available.
- out_ready  in  1  consumer accepts when out_valid&&out_ready.
- busy  out  1  high in WARMUP or SAMPLE.
- health_fail  out  1  sticky error flag; cleared only by reset or by start in FAIL.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state IDLE; challenge=0; out_valid=0; busy=0; health_fail=0.
  - all counters 0; RCT history cleared.
- States:
  - IDLE: start -> clear challenge and counters; go to WARMUP if WARMUP>0, else SAMPLE.
  - WARMUP: each accepted bit increments wcnt and feeds the RCT only. After the WARMUP-th bit -> SAMPLE next cycle.
  - SAMPLE: each accepted bit shifts into challenge per MSB_FIRST and increments scnt. On the WIDTH-th bit -> HOLD; out_valid=1 from the next cycle.
  - HOLD: out_valid=1, challenge frozen. On out_valid&&out_ready -> IDLE next cycle; out_valid=0; challenge keeps its value.
  - FAIL: out_valid=0, busy=0, health_fail=1. start -> clear health_fail and proceed as from IDLE. abort -> IDLE with health_fail kept.
- Latency: with bit_valid held 1, out_valid rises (WARMUP+WIDTH+1) cycles after the start cycle. Default: 81.
- Counters:
  - wcnt width $clog2(WARMUP+1); scnt width $clog2(WIDTH+1).
  - Compare against parameter values; no wrap-around inside a run.
- RCT:
  - Tracks last accepted bit and run length (8 bits, saturating).
  - The first accepted bit after start sets run=1.
  - Run reaching RCT_LIMIT in WARMUP or SAMPLE -> FAIL next cycle; a partial challenge is never presented.
- Simultaneous events:
  - start while not IDLE/FAIL is ignored.
  - abort has priority over start, bit acceptance, RCT trip and the handshake, and discards partial data.
  - WIDTH-th bit plus RCT trip in the same cycle -> FAIL wins.
  - Handshake and start in the same cycle in HOLD -> start ignored; the consumer re-requests.
- bit_valid=0 stalls the counters and the RCT with no timeout.

Decomposition:
- Package cmac_rng_pkg:
  - typedef enum logic [2:0] rng_state_t {IDLE, WARMUP, SAMPLE, HOLD, FAIL}.
  - localparam RCT_CNT_W = 8.
- Sub-module rng_rct_monitor:
  - Inputs: clk, reset, clear, bit_in, bit_accept.
  - Output: trip.
  - Parameter: RCT_LIMIT.
- Top holds the FSM, counters and shift register.

Test Plan:
- Defaults, alternating 1,0 stream, bit_valid=1, start at cycle 0:
  - First 16 bits discarded; out_valid rises at cycle 81.
  - challenge = 64'hAAAA_AAAA_AAAA_AAAA with MSB_FIRST=0 (first kept bit =1).
  - Held until out_ready=1, then IDLE.
- WIDTH=8, WARMUP=0, MSB_FIRST=1, bits 1,1,0,1,0,0,1,0 -> challenge = 8'h4B; latency 9 cycles.
- Constant 0 stream, RCT_LIMIT=24, WARMUP=16:
  - FAIL entered one cycle after the 24th bit (8th sample bit).
  - health_fail=1, out_valid never asserts.
  - A later start clears health_fail.
- bit_valid toggling 1,0 with alternating data, WIDTH=8, WARMUP=0 -> out_valid at cycle 16 after start; same word as the ungapped run.
- abort at the 30th sample bit -> IDLE next cycle, busy=0; the next start produces a fresh full-length word.
- Reset asserted asynchronously mid-SAMPLE (between clock edges) -> all outputs 0 immediately; start ignored while reset=0.
